// File: rtl/fifo_defs_pkg.sv
// Shared definitions for the parametrised FIFO family: default sizes,
// the status bundle and the occupancy-counter width helper.
package fifo_defs_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

  // Occupancy runs 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-side bundle of fifo_param. The overflow/underflow
// members exist only when FIFO_ERR_EN is defined.
interface fifo_param_if #(
  parameter int WIDTH = fifo_defs_pkg::FIFO_DEF_WIDTH,
  parameter int DEPTH = fifo_defs_pkg::FIFO_DEF_DEPTH
) ();
  import fifo_defs_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] din;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
`ifdef FIFO_ERR_EN
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr, rd,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  din, wr, rd,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
`else
  modport master (
    output din, wr, rd,
    input  dout, empty, full, almost_empty, almost_full, count
  );
  modport slave (
    input  din, wr, rd,
    output dout, empty, full, almost_empty, almost_full, count
  );
`endif

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage for fifo_param: synchronous write, registered
// synchronous read whose output register clears on reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // NOTE: the array has no reset so it can map onto RAM macros; the FIFO
  // never reads an entry it has not written since reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: every always_comb output gets its default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample pre-edge values; a same-address write and read returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count and status
// decode. Optional sticky overflow/underflow flags under FIFO_ERR_EN.
module fifo_param
  import fifo_defs_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fifo_param_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wptr_d, wptr_q;
  logic [AW-1:0] rptr_d, rptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          wr_ok, rd_ok;
  fifo_status_t  status;

  // Status depends on the registered count only, never on wr/rd.
  always_comb begin
    status.empty        = (count_q == '0);
    status.full         = (count_q == CW'(DEPTH));
    status.almost_empty = (count_q <= CW'(AE_THRESH));
    status.almost_full  = (count_q >= CW'(AF_THRESH));
  end

  // A write into a full FIFO is legal when a read frees the slot that edge.
  assign wr_ok = bus.wr && (!status.full || bus.rd);
  assign rd_ok = bus.rd && !status.empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + AW'(1);
    if (rd_ok) rptr_d = rptr_q + AW'(1);
    if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (bus.din),
    .re    (rd_ok),
    .raddr (rptr_q),
    .rdata (bus.dout)
  );

`ifdef FIFO_ERR_EN
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;

  always_comb begin
    overflow_d  = overflow_q  | (bus.wr && status.full && !bus.rd);
    underflow_d = underflow_q | (bus.rd && status.empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  assign bus.empty        = status.empty;
  assign bus.full         = status.full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param (WIDTH=8, DEPTH=16, AF=14, AE=2); the
// error-flag checks are active when FIFO_ERR_EN is defined.
module tb_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb [$];
  logic [7:0] exp_dout = 8'h00;
  int         m_count  = 0;
  logic       m_ovf    = 1'b0;
  logic       m_unf    = 1'b0;
  logic       saw_aa   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " dout"},  32'(bus.dout), 32'(exp_dout));
    check({tag, " count"}, 32'(bus.count), 32'(m_count));
    check({tag, " status"},
          {28'd0, bus.empty, bus.full, bus.almost_empty, bus.almost_full},
          {28'd0, m_count == 0, m_count == DEPTH, m_count <= AE, m_count >= AF});
`ifdef FIFO_ERR_EN
    check({tag, " overflow"},  32'(bus.overflow),  32'(m_ovf));
    check({tag, " underflow"}, 32'(bus.underflow), 32'(m_unf));
`endif
  endtask

  // One clock: drive, advance the model and scoreboard, sample 1ns after the edge.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    bus.wr  = w;
    bus.rd  = r;
    bus.din = d;
    wa = w && (m_count != DEPTH || r);
    ra = r && (m_count != 0);
    if (w && m_count == DEPTH && !r) m_ovf = 1'b1;
    if (r && m_count == 0)           m_unf = 1'b1;
    if (ra) exp_dout = sb.pop_front();
    if (wa) sb.push_back(d);
    if (wa && !ra) m_count++;
    if (ra && !wa) m_count--;
    @(posedge clk);
    #1;
    if (bus.dout == 8'hAA) saw_aa = 1'b1;
    check_outputs(tag);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  initial begin
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.din = '0;

    // Reset held for 5 cycles, checked while asserted.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i >= 1) check_outputs("reset");
    end
    rst = 1'b0;

    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
    cycle("overflow", 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
    cycle("underflow", 1'b0, 1'b1, 8'h00);
    check("no_aa_seen", 32'(saw_aa), 32'd0);

    for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) cycle("full_rdwr", 1'b1, 1'b1, 8'(8'h30 + i));
    for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 1'b1, 8'h00);
    cycle("empty_rdwr", 1'b1, 1'b1, 8'h77);
    cycle("read77", 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 7; i++) cycle("fill7", 1'b1, 1'b0, 8'(8'h60 + i));

    // Asynchronous reset between edges with count == 7.
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    m_count  = 0;
    exp_dout = 8'h00;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    check_outputs("async_rst");
    #1;
    rst = 1'b0;

    cycle("post_rst_wr", 1'b1, 1'b0, 8'h55);
    cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
